// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // A write to x0 is architecturally discarded, so it never creates a dependency.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// E-stage operand forward select for one source register; M-stage producer wins over W.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] ra_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (reg_hit(reg_write_m_i, rd_m_i, ra_e_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_hit(reg_write_w_i, rd_w_i, ra_e_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush, memory-freeze and halt-drain control for the 5-stage pipeline.
// Define FORWARDING_EN to resolve RAW hazards by forwarding instead of stalling.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TCNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ra1D,
  input  logic [4:0] ra2D,
  input  logic [4:0] ra1E,
  input  logic [4:0] ra2E,
  input  logic [4:0] rdE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       reg_writeE,
  input  logic       reg_writeM,
  input  logic       reg_writeW,
  input  logic       mem_to_regE,
  input  logic       pc_srcE,
  input  logic       jumpE,
  input  logic       hltE,
  input  logic       hltW,
  input  logic       mem_reqM,
  input  logic       mem_readyM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushW,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       halted,
  output logic       mem_timeout
);

  localparam logic [TCNT_W-1:0] TLimit = TCNT_W'(MEM_TIMEOUT);

  hz_state_t         state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic       lwstall, cc, mwait, hz_stall;
  logic [1:0] fwd_a, fwd_b;

  assign lwstall = mem_to_regE && (rdE != 5'd0) && ((rdE == ra1D) || (rdE == ra2D));
  assign cc      = pc_srcE | jumpE;
  assign mwait   = mem_reqM & ~mem_readyM;

`ifdef FORWARDING_EN
  fwd_sel u_fwd_a (
    .ra_e_i        (ra1E),
    .rd_m_i        (rdM),
    .rd_w_i        (rdW),
    .reg_write_m_i (reg_writeM),
    .reg_write_w_i (reg_writeW),
    .sel_o         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .ra_e_i        (ra2E),
    .rd_m_i        (rdM),
    .rd_w_i        (rdW),
    .reg_write_m_i (reg_writeM),
    .reg_write_w_i (reg_writeW),
    .sel_o         (fwd_b)
  );

  assign hz_stall = lwstall;
`else
  // W-stage producers need no stall: the register file writes through to the D-stage read.
  logic unused_nofwd;
  assign unused_nofwd = ^{ra1E, ra2E, rdW, reg_writeW};
  assign fwd_a        = FWD_RF;
  assign fwd_b        = FWD_RF;
  assign hz_stall     = lwstall
                      | reg_hit(reg_writeE, rdE, ra1D) | reg_hit(reg_writeE, rdE, ra2D)
                      | reg_hit(reg_writeM, rdM, ra1D) | reg_hit(reg_writeM, rdM, ra2D);
`endif

  always_comb begin
    state_d       = state_q;
    tcnt_d        = '0;
    mem_timeout_d = mem_timeout_q;
    if (mwait) begin
      tcnt_d        = (tcnt_q == TLimit) ? tcnt_q : tcnt_q + TCNT_W'(1);
      mem_timeout_d = mem_timeout_q | (tcnt_d == TLimit);
    end else begin
      case (state_q)
        RUN:     if (hltE) state_d = DRAIN;
        DRAIN:   if (hltW) state_d = HALTED;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (reset) begin
      // everything quiet during the reset cycle
    end else if (state_q == HALTED) begin
      {stallF, stallD, stallE, stallM} = 4'b1111;
      flushE = 1'b1;
      flushW = 1'b1;
    end else if (mwait) begin
      {stallF, stallD, stallE, stallM} = 4'b1111;
      flushW = 1'b1;
    end else begin
      forwardAE = fwd_a;
      forwardBE = fwd_b;
      if (state_q == DRAIN) begin
        stallF = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
      end else begin
        // A control change discards the stalled instruction, so the new PC must be fetched.
        stallF = hz_stall & ~cc;
        stallD = hz_stall & ~cc;
        flushE = hz_stall | cc;
        flushD = cc;
      end
    end
  end

  assign halted      = (state_q == HALTED);
  assign mem_timeout = mem_timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      tcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW;
  logic       reg_writeE, reg_writeM, reg_writeW, mem_to_regE;
  logic       pc_srcE, jumpE, hltE, hltW, mem_reqM, mem_readyM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic       halted, mem_timeout;

  typedef struct {
    string      name;
    logic [12:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (255),
    .TCNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ra1D        (ra1D),
    .ra2D        (ra2D),
    .ra1E        (ra1E),
    .ra2E        (ra2E),
    .rdE         (rdE),
    .rdM         (rdM),
    .rdW         (rdW),
    .reg_writeE  (reg_writeE),
    .reg_writeM  (reg_writeM),
    .reg_writeW  (reg_writeW),
    .mem_to_regE (mem_to_regE),
    .pc_srcE     (pc_srcE),
    .jumpE       (jumpE),
    .hltE        (hltE),
    .hltW        (hltW),
    .mem_reqM    (mem_reqM),
    .mem_readyM  (mem_readyM),
    .stallF      (stallF),
    .stallD      (stallD),
    .stallE      (stallE),
    .stallM      (stallM),
    .flushD      (flushD),
    .flushE      (flushE),
    .flushW      (flushW),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .halted      (halted),
    .mem_timeout (mem_timeout)
  );

  // {stallF,stallD,stallE,stallM}, {flushD,flushE,flushW}, fwdA, fwdB, halted, mem_timeout
  function automatic logic [12:0] ex(input logic [3:0] st, input logic [2:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic h, input logic t);
    return {st, fl, fa, fb, h, t};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        item;
      logic [12:0] act;
      item = exp_q.pop_front();
      act  = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
              forwardAE, forwardBE, halted, mem_timeout};
      total++;
      if (act !== item.exp) begin
        bad++;
        $display("FAIL %s: got %b want %b", item.name, act, item.exp);
      end
    end
  end

  task automatic idle_inputs();
    ra1D = 5'd0; ra2D = 5'd0; ra1E = 5'd0; ra2E = 5'd0;
    rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
    reg_writeE = 1'b0; reg_writeM = 1'b0; reg_writeW = 1'b0; mem_to_regE = 1'b0;
    pc_srcE = 1'b0; jumpE = 1'b0; hltE = 1'b0; hltW = 1'b0;
    mem_reqM = 1'b0; mem_readyM = 1'b0;
  endtask

  // Inputs are already set; queue the expectation, let the monitor sample, advance one cycle.
  task automatic apply(input string name, input logic [12:0] exp);
    exp_t item;
    item.name = name;
    item.exp  = exp;
    exp_q.push_back(item);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    apply("reset", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
    reset = 1'b0;
    apply("idle", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));

    reg_writeM = 1'b1; rdM = 5'd5; ra1E = 5'd5;
    apply("fwd_m", ex(4'b0000, 3'b000, Fwd ? 2'b10 : 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    reg_writeW = 1'b1; rdW = 5'd5; ra1E = 5'd5; ra2E = 5'd5;
    apply("fwd_w", ex(4'b0000, 3'b000, Fwd ? 2'b01 : 2'b00, Fwd ? 2'b01 : 2'b00, 1'b0, 1'b0));
    idle_inputs();
    reg_writeM = 1'b1; rdM = 5'd7; reg_writeW = 1'b1; rdW = 5'd7; ra2E = 5'd7;
    apply("fwd_prio", ex(4'b0000, 3'b000, 2'b00, Fwd ? 2'b10 : 2'b00, 1'b0, 1'b0));
    idle_inputs();
    reg_writeM = 1'b1; reg_writeW = 1'b1;
    apply("fwd_x0", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));

    idle_inputs();
    mem_to_regE = 1'b1; reg_writeE = 1'b1; rdE = 5'd6; ra1D = 5'd6;
    apply("lwstall", ex(4'b1100, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    reg_writeM = 1'b1; rdM = 5'd6; ra1D = 5'd6;
    apply("lw_bubble", ex(Fwd ? 4'b0000 : 4'b1100, Fwd ? 3'b000 : 3'b010, 2'b00, 2'b00,
                          1'b0, 1'b0));
    idle_inputs();
    reg_writeW = 1'b1; rdW = 5'd6; ra1E = 5'd6;
    apply("lw_fwd", ex(4'b0000, 3'b000, Fwd ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    reg_writeE = 1'b1; rdE = 5'd3; ra2D = 5'd3;
    apply("raw_e_alu", ex(Fwd ? 4'b0000 : 4'b1100, Fwd ? 3'b000 : 3'b010, 2'b00, 2'b00,
                          1'b0, 1'b0));

    idle_inputs();
    pc_srcE = 1'b1; mem_to_regE = 1'b1; reg_writeE = 1'b1; rdE = 5'd6; ra1D = 5'd6;
    apply("cc_lw", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    jumpE = 1'b1;
    apply("jump", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0));

    idle_inputs();
    mem_reqM = 1'b1; reg_writeM = 1'b1; rdM = 5'd5; ra1E = 5'd5; pc_srcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply("mwait", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0));
    end
    idle_inputs();
    mem_reqM = 1'b1; mem_readyM = 1'b1;
    apply("mem_done", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));

    idle_inputs();
    hltE = 1'b1; pc_srcE = 1'b1;
    apply("halt_cc", ex(4'b0000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    apply("drain", ex(4'b1000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0));
    mem_reqM = 1'b1; hltW = 1'b1;
    apply("drain_wait", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    hltW = 1'b1;
    apply("drain_hltw", ex(4'b1000, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0));
    idle_inputs();
    apply("halted", ex(4'b1111, 3'b011, 2'b00, 2'b00, 1'b1, 1'b0));
    hltE = 1'b1; jumpE = 1'b1;
    apply("halted_hold", ex(4'b1111, 3'b011, 2'b00, 2'b00, 1'b1, 1'b0));
    idle_inputs();
    reset = 1'b1;
    apply("reset_halt", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));
    reset = 1'b0;
    apply("after_reset", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));

    mem_reqM = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      apply("timeout_wait", ex(4'b1111, 3'b001, 2'b00, 2'b00, 1'b0, (k >= 256) ? 1'b1 : 1'b0));
    end
    idle_inputs();
    apply("to_release", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1));
    apply("to_sticky", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1));
    reset = 1'b1;
    apply("to_reset", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1));
    reset = 1'b0;
    apply("to_cleared", ex(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
